// File: rtl/phase_incr_estimator_if.sv
// Sample-stream / measurement bundle for phase_incr_estimator.
// master drives the sawtooth samples, slave returns the phase-increment measurement.
interface phase_incr_estimator_if #(
  parameter int CNT_W = 24
) ();
  logic               step_in;
  logic signed [31:0] amp_in;
  logic        [31:0] phase_incr_out;
  logic   [CNT_W-1:0] period_out;
  logic               valid_out;
  logic               no_signal_out;

  modport master (
    output step_in, amp_in,
    input  phase_incr_out, period_out, valid_out, no_signal_out
  );

  modport slave (
    input  step_in, amp_in,
    output phase_incr_out, period_out, valid_out, no_signal_out
  );
endinterface

// File: rtl/phase_incr_estimator.sv
// Recovers PHASE_INCR = 2^32/period from a sawtooth stream by averaging 2^AVG_LOG2 periods.
// Optional HYSTERESIS_EN macro qualifies wraps with a +/-HYST_THRESH magnitude test.
module phase_incr_estimator #(
  parameter int          AVG_LOG2    = 2,
  parameter int          CNT_W       = 24,
  parameter logic [31:0] HYST_THRESH = 32'h0010_0000
) (
  input logic                   clk_in,
  input logic                   rst_n_in,
  phase_incr_estimator_if.slave bus
);
  localparam int                S_W     = CNT_W + AVG_LOG2;
  localparam int                R_W     = S_W + 1;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [AVG_LOG2:0] WIN_LEN = (AVG_LOG2 + 1)'(1 << AVG_LOG2);

  typedef enum logic {ACQUIRE, COUNT} win_state_e;
  typedef enum logic [1:0] {IDLE, DIV, DONE} div_state_e;

  win_state_e         win_state_q, win_state_d;
  div_state_e         div_state_q, div_state_d;
  logic signed [31:0] prev_amp_q, prev_amp_d;
  logic               prev_vld_q, prev_vld_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [S_W-1:0]     acc_q, acc_d;
  logic [AVG_LOG2:0]  idx_q, idx_d;
  logic               snap_vld_q, snap_vld_d;
  logic [S_W-1:0]     snap_q, snap_d;
  logic [S_W-1:0]     divisor_q, divisor_d;
  logic [R_W-1:0]     rem_q, rem_d;
  logic [31:0]        quot_q, quot_d;
  logic [4:0]         iter_q, iter_d;
  logic               sat_q, sat_d;
  logic [31:0]        phase_incr_q, phase_incr_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               valid_q, valid_d;
  logic               no_signal_q, no_signal_d;

  logic               wrap;
  logic               timeout;
  logic [S_W-1:0]     period_sum;
  logic [R_W-1:0]     rem_sh;
  logic               unused_bits;

  function automatic logic [31:0] sat_quot(input logic [31:0] q, input logic ovf);
    return ovf ? 32'hFFFF_FFFF : q;
  endfunction

  always_comb begin
    wrap = prev_vld_q && !prev_amp_q[31] && bus.amp_in[31];
`ifdef HYSTERESIS_EN
    wrap = wrap && (prev_amp_q >= $signed(HYST_THRESH)) &&
           (bus.amp_in <= -$signed(HYST_THRESH));
`endif
  end

  assign timeout    = bus.step_in && prev_vld_q && !wrap && (cnt_q == CNT_MAX - 1'b1);
  assign period_sum = acc_q + S_W'(cnt_q) + S_W'(1);
  assign rem_sh     = {rem_q[R_W-2:0], 1'b0};

  // Window side: wrap detection, per-period counting and snapshot of 2^AVG_LOG2 periods
  always_comb begin
    win_state_d = win_state_q;
    prev_amp_d  = prev_amp_q;
    prev_vld_d  = prev_vld_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    snap_vld_d  = 1'b0;
    snap_d      = snap_q;
    if (bus.step_in) begin
      prev_amp_d = bus.amp_in;
      prev_vld_d = 1'b1;
      if (wrap) begin
        cnt_d = '0;
        if (win_state_q == ACQUIRE) begin
          win_state_d = COUNT;
          acc_d       = '0;
          idx_d       = '0;
        end else if (idx_q + 1'b1 == WIN_LEN) begin
          snap_vld_d = 1'b1;
          snap_d     = period_sum;
          acc_d      = '0;
          idx_d      = '0;
        end else begin
          acc_d = period_sum;
          idx_d = idx_q + 1'b1;
        end
      end else if (prev_vld_q) begin
        if (timeout) begin
          win_state_d = ACQUIRE;
          cnt_d       = '0;
          acc_d       = '0;
          idx_d       = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  // Divider side: remainder starts at 2^AVG_LOG2, so 32 shift steps yield 2^(32+AVG_LOG2)/S
  always_comb begin
    div_state_d  = div_state_q;
    divisor_d    = divisor_q;
    rem_d        = rem_q;
    quot_d       = quot_q;
    iter_d       = iter_q;
    sat_d        = sat_q;
    phase_incr_d = phase_incr_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    no_signal_d  = no_signal_q;
    case (div_state_q)
      IDLE: begin
        if (snap_vld_q) begin
          divisor_d   = snap_q;
          rem_d       = R_W'(WIN_LEN);
          sat_d       = (snap_q <= S_W'(WIN_LEN));
          quot_d      = '0;
          iter_d      = '0;
          div_state_d = DIV;
        end
      end
      DIV: begin
        if (rem_sh >= {1'b0, divisor_q}) begin
          rem_d  = rem_sh - {1'b0, divisor_q};
          quot_d = {quot_q[30:0], 1'b1};
        end else begin
          rem_d  = rem_sh;
          quot_d = {quot_q[30:0], 1'b0};
        end
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'd31) div_state_d = DONE;
      end
      DONE: begin
        phase_incr_d = sat_quot(quot_q, sat_q);
        period_d     = CNT_W'(divisor_q >> AVG_LOG2);
        valid_d      = 1'b1;
        no_signal_d  = 1'b0;
        div_state_d  = IDLE;
      end
      default: div_state_d = IDLE;
    endcase
    if (timeout) begin
      div_state_d  = IDLE;
      valid_d      = 1'b0;
      phase_incr_d = '0;
      no_signal_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      win_state_q  <= ACQUIRE;
      div_state_q  <= IDLE;
      prev_amp_q   <= '0;
      prev_vld_q   <= 1'b0;
      cnt_q        <= '0;
      acc_q        <= '0;
      idx_q        <= '0;
      snap_vld_q   <= 1'b0;
      snap_q       <= '0;
      divisor_q    <= '0;
      rem_q        <= '0;
      quot_q       <= '0;
      iter_q       <= '0;
      sat_q        <= 1'b0;
      phase_incr_q <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      no_signal_q  <= 1'b1;
    end else begin
      win_state_q  <= win_state_d;
      div_state_q  <= div_state_d;
      prev_amp_q   <= prev_amp_d;
      prev_vld_q   <= prev_vld_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      snap_vld_q   <= snap_vld_d;
      snap_q       <= snap_d;
      divisor_q    <= divisor_d;
      rem_q        <= rem_d;
      quot_q       <= quot_d;
      iter_q       <= iter_d;
      sat_q        <= sat_d;
      phase_incr_q <= phase_incr_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      no_signal_q  <= no_signal_d;
    end
  end

  assign bus.phase_incr_out = phase_incr_q;
  assign bus.period_out     = period_q;
  assign bus.valid_out      = valid_q;
  assign bus.no_signal_out  = no_signal_q;

  assign unused_bits = ^{rem_q[R_W-1], prev_amp_q[30:0], HYST_THRESH};
endmodule

// File: tb/tb_phase_incr_estimator.sv
// Bench for phase_incr_estimator: sawtooth stimulus, window/period model, per-cycle compare.
module tb_phase_incr_estimator;
  localparam int          CNT_W    = 10;
  localparam int          AVG_LOG2 = 2;
  localparam int          WIN      = 1 << AVG_LOG2;
  localparam int          TMO      = (1 << CNT_W) - 1;
  localparam int          LAT      = 34;
  localparam logic [31:0] HYST     = 32'h0010_0000;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b1;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   n_valid  = 0;
  int   v0;

  phase_incr_estimator_if #(.CNT_W(CNT_W)) bus ();

  phase_incr_estimator #(.AVG_LOG2(AVG_LOG2), .CNT_W(CNT_W), .HYST_THRESH(HYST)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    longint           due;
    logic [31:0]      phase;
    logic [CNT_W-1:0] period;
  } ev_t;

  longint           cyc = 0;
  bit               m_have_prev, m_synced;
  logic signed [31:0] m_prev;
  int               m_since;
  int               m_periods[$];
  ev_t              m_pend[$];
  ev_t              m_ev;
  longint           m_sum, m_q;
  logic [31:0]      exp_phase  = '0;
  logic [CNT_W-1:0] exp_period = '0;
  logic             exp_nosig  = 1'b1;
  logic             exp_valid  = 1'b0;

  function automatic bit is_wrap(input logic signed [31:0] p, input logic signed [31:0] a);
`ifdef HYSTERESIS_EN
    return (p >= 0) && (a < 0) && (p >= $signed(HYST)) && (a <= -$signed(HYST));
`else
    return (p >= 0) && (a < 0);
`endif
  endfunction

  initial forever begin
    @(posedge clk_in);
    cyc++;
    exp_valid = 1'b0;
    if (!rst_n_in) begin
      m_have_prev = 0; m_synced = 0; m_since = 0;
      m_periods.delete(); m_pend.delete();
      exp_phase = '0; exp_period = '0; exp_nosig = 1'b1;
    end else begin
      if (m_pend.size() != 0 && m_pend[0].due == cyc) begin
        exp_phase  = m_pend[0].phase;
        exp_period = m_pend[0].period;
        exp_nosig  = 1'b0;
        exp_valid  = 1'b1;
        void'(m_pend.pop_front());
      end
      if (bus.step_in) begin
        if (!m_have_prev) begin
          m_have_prev = 1;
        end else if (is_wrap(m_prev, bus.amp_in)) begin
          if (m_synced) begin
            m_periods.push_back(m_since + 1);
            if (m_periods.size() == WIN) begin
              m_sum = 0;
              foreach (m_periods[i]) m_sum += m_periods[i];
              m_q = (longint'(1) << (32 + AVG_LOG2)) / m_sum;
              if (m_q > 64'hFFFF_FFFF) m_q = 64'hFFFF_FFFF;
              if (m_pend.size() == 0) begin
                m_ev.due    = cyc + LAT;
                m_ev.phase  = 32'(m_q);
                m_ev.period = CNT_W'(m_sum / WIN);
                m_pend.push_back(m_ev);
              end
              m_periods.delete();
            end
          end else begin
            m_synced = 1;
            m_periods.delete();
          end
          m_since = 0;
        end else begin
          m_since++;
          if (m_since == TMO) begin
            m_synced = 0; m_since = 0;
            m_periods.delete(); m_pend.delete();
            exp_phase = '0; exp_nosig = 1'b1; exp_valid = 1'b0;
          end
        end
        m_prev = bus.amp_in;
      end
    end
  end

  // ---------------- compare process ----------------
  initial forever begin
    @(posedge clk_in);
    #1;
    if (bus.valid_out === 1'b1) n_valid++;
    chk("valid_out", 64'(bus.valid_out), 64'(exp_valid));
    chk("outputs", 64'({bus.phase_incr_out, bus.period_out, bus.no_signal_out}),
        64'({exp_phase, exp_period, exp_nosig}));
  end

  // ---------------- stimulus ----------------
  function automatic logic signed [31:0] saw(input int k, input int p, input bit dith);
    longint      stp;
    logic [31:0] u;
    stp = 64'sh1_0000_0000 / p;
    u = 32'(longint'(k % p) * stp);
    if (dith && (k % p) == 0) u = 32'd100;
    if (dith && (k % p) == 1) u = 32'hFFFF_FF9C;
    return $signed(u);
  endfunction

  task automatic drive_saw(input int p, input int n, input int gap, input bit dith);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_in);
      bus.step_in = 1'b1;
      bus.amp_in  = saw(k, p, dith);
      repeat (gap - 1) begin
        @(negedge clk_in);
        bus.step_in = 1'b0;
      end
    end
    @(negedge clk_in);
    bus.step_in = 1'b0;
  endtask

  task automatic drive_const(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_in);
      bus.step_in = 1'b1;
      bus.amp_in  = '0;
    end
    @(negedge clk_in);
    bus.step_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    rst_n_in = 1'b0;
    idle(2);
    chk("rst_phase", 64'(bus.phase_incr_out), 64'h0);
    chk("rst_nosig", 64'(bus.no_signal_out), 64'h1);
    rst_n_in = 1'b1;
  endtask

  initial begin
    bus.step_in = 1'b0;
    bus.amp_in  = '0;
    #1 rst_n_in = 1'b0;
    idle(3);
    chk("reset_phase",  64'(bus.phase_incr_out), 64'h0);
    chk("reset_period", 64'(bus.period_out),     64'h0);
    chk("reset_valid",  64'(bus.valid_out),      64'h0);
    chk("reset_nosig",  64'(bus.no_signal_out),  64'h1);
    rst_n_in = 1'b1;

    // period 64, one step per cycle
    v0 = n_valid;
    drive_saw(64, 384, 1, 1'b0);
    idle(50);
    chk("p64_phase",  64'(bus.phase_incr_out), 64'h0400_0000);
    chk("p64_period", 64'(bus.period_out),     64'd64);
    chk("p64_nosig",  64'(bus.no_signal_out),  64'h0);
    chk("p64_pulses", 64'(n_valid - v0),       64'd1);

    // period 100, step every 3rd cycle
    do_reset();
    v0 = n_valid;
    drive_saw(100, 1000, 3, 1'b0);
    idle(50);
    chk("p100_phase",  64'(bus.phase_incr_out), 64'h028F_5C28);
    chk("p100_period", 64'(bus.period_out),     64'd100);
    chk("p100_pulses", 64'(n_valid - v0),       64'd2);

    // lock, then lose the signal until the sample-count timeout, then relock
    do_reset();
    drive_saw(64, 384, 1, 1'b0);
    idle(50);
    chk("pre_tmo_phase", 64'(bus.phase_incr_out), 64'h0400_0000);
    v0 = n_valid;
    drive_const(1024);
    idle(5);
    chk("tmo_phase",  64'(bus.phase_incr_out), 64'h0);
    chk("tmo_nosig",  64'(bus.no_signal_out),  64'h1);
    chk("tmo_pulses", 64'(n_valid - v0),       64'd0);
    v0 = n_valid;
    drive_saw(64, 384, 1, 1'b0);
    idle(50);
    chk("relock_phase",  64'(bus.phase_incr_out), 64'h0400_0000);
    chk("relock_nosig",  64'(bus.no_signal_out),  64'h0);
    chk("relock_pulses", 64'(n_valid - v0),       64'd1);

    // reset ten cycles after the window-closing step (divide in flight)
    do_reset();
    v0 = n_valid;
    drive_saw(64, 289, 1, 1'b0);
    idle(9);
    rst_n_in = 1'b0;
    idle(1);
    chk("mid_rst_phase",  64'(bus.phase_incr_out), 64'h0);
    chk("mid_rst_period", 64'(bus.period_out),     64'h0);
    chk("mid_rst_nosig",  64'(bus.no_signal_out),  64'h1);
    idle(40);
    chk("mid_rst_pulses", 64'(n_valid - v0),       64'd0);
    rst_n_in = 1'b1;
    drive_saw(64, 384, 1, 1'b0);
    idle(50);
    chk("post_rst_phase",  64'(bus.phase_incr_out), 64'h0400_0000);
    chk("post_rst_period", 64'(bus.period_out),     64'd64);

    // dither of +/-100 around the upward zero crossing
    do_reset();
    drive_saw(64, 384, 1, 1'b1);
    idle(50);
`ifdef HYSTERESIS_EN
    chk("dither_phase",  64'(bus.phase_incr_out), 64'h0400_0000);
    chk("dither_period", 64'(bus.period_out),     64'd64);
`else
    chk("dither_phase",  64'(bus.phase_incr_out), 64'h0800_0000);
    chk("dither_period", 64'(bus.period_out),     64'd32);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
